// File: rtl/tictactoe_pkg.sv
// Shared encodings and state type for the tic-tac-toe board controller.
package tictactoe_pkg;

  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;

  localparam int unsigned CELL_IDX_MIN = 1;
  localparam int unsigned CELL_IDX_MAX = 9;
  localparam int unsigned NUM_CELLS    = 9;

  typedef enum logic [2:0] {
    StPlayer,
    StComputer,
    StCheckP,
    StCheckC,
    StOver
  } state_e;

endpackage

// File: rtl/tictactoe_board_ctrl_if.sv
// Move strobes, winner-detector feedback and board/status outputs of the board controller.
interface tictactoe_board_ctrl_if;
  logic       play;
  logic [3:0] player_pos;
  logic       pc;
  logic [3:0] computer_pos;
  logic       winner;
  logic [1:0] who;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       player_turn;
  logic       illegal_move;
  logic       game_over;
  logic       draw;
  logic [1:0] win_who;

  modport master (
    output play, player_pos, pc, computer_pos, winner, who,
    input  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
    input  player_turn, illegal_move, game_over, draw, win_who
  );

  modport slave (
    input  play, player_pos, pc, computer_pos, winner, who,
    output pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
    output player_turn, illegal_move, game_over, draw, win_who
  );
endinterface

// File: rtl/cell_index_decoder.sv
// Maps a 1-based 4-bit cell index to a 9-bit one-hot; out-of-range indices give all zeros.
module cell_index_decoder
  import tictactoe_pkg::*;
(
  input  logic [3:0] idx_i,
  output logic [8:0] onehot_o,
  output logic       in_range_o
);

  always_comb begin
    in_range_o = (32'(idx_i) >= CELL_IDX_MIN) && (32'(idx_i) <= CELL_IDX_MAX);
    onehot_o   = '0;
    if (in_range_o) begin
      onehot_o = 9'd1 << (idx_i - 4'd1);
    end
  end

endmodule

// File: rtl/tictactoe_board_ctrl.sv
// Tic-tac-toe board registers and turn sequencing; the winner detector sits outside and
// feeds back on the registered board, so there is no combinational loop.
module tictactoe_board_ctrl
  import tictactoe_pkg::*;
#(
  parameter bit FIRST_MOVER = 1'b0
) (
  input logic                  clock,
  input logic                  reset_n,
  input logic                  clear,
  tictactoe_board_ctrl_if.slave bus
);

  logic [8:0][1:0] board_q;
  state_e          state_q;
  logic            player_turn_q;
  logic            illegal_q;
  logic            game_over_q;
  logic            draw_q;
  logic [1:0]      win_who_q;

  logic [8:0] p_hot, c_hot, occupied;
  logic       p_in, c_in, p_ok, c_ok;

  cell_index_decoder u_player_dec (
    .idx_i      (bus.player_pos),
    .onehot_o   (p_hot),
    .in_range_o (p_in)
  );

  cell_index_decoder u_computer_dec (
    .idx_i      (bus.computer_pos),
    .onehot_o   (c_hot),
    .in_range_o (c_in)
  );

  always_comb begin
    occupied = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      occupied[i] = (board_q[i] != CELL_EMPTY);
    end
  end

  // A move is legal only into an in-range, currently empty cell.
  assign p_ok = p_in && ((p_hot & occupied) == '0);
  assign c_ok = c_in && ((c_hot & occupied) == '0);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      board_q       <= '0;
      state_q       <= FIRST_MOVER ? StComputer : StPlayer;
      player_turn_q <= !FIRST_MOVER;
      illegal_q     <= 1'b0;
      game_over_q   <= 1'b0;
      draw_q        <= 1'b0;
      win_who_q     <= CELL_EMPTY;
    end else begin
      illegal_q <= 1'b0;
      unique case (state_q)
        StPlayer: begin
          if (bus.play) begin
            if (p_ok) begin
              for (int i = 0; i < NUM_CELLS; i++) begin
                if (p_hot[i]) board_q[i] <= CELL_PLAYER;
              end
              state_q       <= StCheckP;
              player_turn_q <= 1'b0;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        StComputer: begin
          if (bus.pc) begin
            if (c_ok) begin
              for (int i = 0; i < NUM_CELLS; i++) begin
                if (c_hot[i]) board_q[i] <= CELL_COMPUTER;
              end
              state_q <= StCheckC;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        StCheckP, StCheckC: begin
          // Detector outputs already reflect the move committed on the previous edge.
          if (bus.winner) begin
            state_q     <= StOver;
            game_over_q <= 1'b1;
            win_who_q   <= bus.who;
          end else if (&occupied) begin
            state_q     <= StOver;
            game_over_q <= 1'b1;
            draw_q      <= 1'b1;
          end else if (state_q == StCheckP) begin
            state_q <= StComputer;
          end else begin
            state_q       <= StPlayer;
            player_turn_q <= 1'b1;
          end
        end
        StOver: ;
        default: begin
          state_q       <= StOver;
          player_turn_q <= 1'b0;
          game_over_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pos1         = board_q[0];
  assign bus.pos2         = board_q[1];
  assign bus.pos3         = board_q[2];
  assign bus.pos4         = board_q[3];
  assign bus.pos5         = board_q[4];
  assign bus.pos6         = board_q[5];
  assign bus.pos7         = board_q[6];
  assign bus.pos8         = board_q[7];
  assign bus.pos9         = board_q[8];
  assign bus.player_turn  = player_turn_q;
  assign bus.illegal_move = illegal_q;
  assign bus.game_over    = game_over_q;
  assign bus.draw         = draw_q;
  assign bus.win_who      = win_who_q;

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Scoreboard bench: player-first and computer-first controllers share stimulus, each
// checked every cycle against a game-rules model.
module tb_tictactoe_board_ctrl;

  typedef struct packed {
    logic [8:0][1:0] board;
    logic [1:0]      turn;     // mark of the side to move: 1 player, 2 computer
    logic            checking;
    logic            over;
    logic            illegal;
    logic            draw;
    logic [1:0]      win;
  } mstate_t;

  typedef struct packed {
    logic [8:0][1:0] board;
    logic            pt;
    logic            ill;
    logic            go;
    logic            dr;
    logic [1:0]      ww;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  logic clear;
  always #5 clock = ~clock;

  tictactoe_board_ctrl_if bus0 ();
  tictactoe_board_ctrl_if bus1 ();

  tictactoe_board_ctrl #(.FIRST_MOVER(1'b0)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus0)
  );

  tictactoe_board_ctrl #(.FIRST_MOVER(1'b1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus1)
  );

  // Reference winner detector: any line of three equal non-empty marks.
  function automatic logic [1:0] detect(input logic [8:0][1:0] b);
    logic [1:0] w;
    int a, s;
    w = 2'b00;
    for (int k = 0; k < 8; k++) begin
      if (k < 3) begin a = 3 * k; s = 1; end
      else if (k < 6) begin a = k - 3; s = 3; end
      else if (k == 6) begin a = 0; s = 4; end
      else begin a = 2; s = 2; end
      if (b[a] != 2'b00 && b[a] == b[a+s] && b[a] == b[a+2*s]) w = b[a];
    end
    return w;
  endfunction

  logic [8:0][1:0] cells0, cells1;
  assign cells0 = {bus0.pos9, bus0.pos8, bus0.pos7, bus0.pos6, bus0.pos5,
                   bus0.pos4, bus0.pos3, bus0.pos2, bus0.pos1};
  assign cells1 = {bus1.pos9, bus1.pos8, bus1.pos7, bus1.pos6, bus1.pos5,
                   bus1.pos4, bus1.pos3, bus1.pos2, bus1.pos1};
  assign bus0.who    = detect(cells0);
  assign bus0.winner = (bus0.who != 2'b00);
  assign bus1.who    = detect(cells1);
  assign bus1.winner = (bus1.who != 2'b00);

  exp_t act0, act1;
  assign act0 = {cells0, bus0.player_turn, bus0.illegal_move, bus0.game_over, bus0.draw,
                 bus0.win_who};
  assign act1 = {cells1, bus1.player_turn, bus1.illegal_move, bus1.game_over, bus1.draw,
                 bus1.win_who};

  // Game rules: one move per turn into an empty cell, one cycle of judging, then handover.
  function automatic mstate_t step(input mstate_t s, input bit computer_first, input bit rst,
                                   input bit play, input int ppos, input bit pc,
                                   input int cpos);
    mstate_t n;
    logic [1:0] w;
    int empties, pos;
    bit strobe;
    n = s;
    if (rst) begin
      n = '0;
      n.turn = computer_first ? 2'd2 : 2'd1;
      return n;
    end
    n.illegal = 1'b0;
    if (s.over) return n;
    if (s.checking) begin
      n.checking = 1'b0;
      w = detect(s.board);
      empties = 0;
      for (int i = 0; i < 9; i++) if (s.board[i] == 2'b00) empties++;
      if (w != 2'b00) begin
        n.over = 1'b1;
        n.win  = w;
      end else if (empties == 0) begin
        n.over = 1'b1;
        n.draw = 1'b1;
      end else begin
        n.turn = (s.turn == 2'd1) ? 2'd2 : 2'd1;
      end
      return n;
    end
    strobe = (s.turn == 2'd1) ? play : pc;
    pos    = (s.turn == 2'd1) ? ppos : cpos;
    if (strobe) begin
      if (pos >= 1 && pos <= 9 && s.board[pos-1] == 2'b00) begin
        n.board[pos-1] = s.turn;
        n.checking     = 1'b1;
      end else begin
        n.illegal = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic exp_t expect_of(input mstate_t m);
    exp_t e;
    e.board = m.board;
    e.pt    = !m.over && !m.checking && (m.turn == 2'd1);
    e.ill   = m.illegal;
    e.go    = m.over;
    e.dr    = m.draw;
    e.ww    = m.win;
    return e;
  endfunction

  mstate_t m0, m1;
  exp_t    q0[$];
  exp_t    q1[$];
  int      compared = 0;
  int      mismatched = 0;

  task automatic compare(input string tag, input exp_t e, input exp_t a);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s t=%0t: got board=%h turn=%b ill=%b over=%b draw=%b who=%b ; %s",
               tag, $time, a.board, a.pt, a.ill, a.go, a.dr, a.ww,
               $sformatf("required board=%h turn=%b ill=%b over=%b draw=%b who=%b",
                         e.board, e.pt, e.ill, e.go, e.dr, e.ww));
    end
  endtask

  // Monitor: each edge's result is checked 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (q0.size() > 0) compare("first_mover0", q0.pop_front(), act0);
      if (q1.size() > 0) compare("first_mover1", q1.pop_front(), act1);
    end
  end

  task automatic apply(input bit rstn, input bit clr, input bit pl, input int pp,
                       input bit c, input int cp);
    reset_n           = rstn;
    clear             = clr;
    bus0.play         = pl;
    bus1.play         = pl;
    bus0.player_pos   = 4'(pp);
    bus1.player_pos   = 4'(pp);
    bus0.pc           = c;
    bus1.pc           = c;
    bus0.computer_pos = 4'(cp);
    bus1.computer_pos = 4'(cp);
    m0 = step(m0, 1'b0, !rstn || clr, pl, pp, c, cp);
    m1 = step(m1, 1'b1, !rstn || clr, pl, pp, c, cp);
    q0.push_back(expect_of(m0));
    q1.push_back(expect_of(m1));
  endtask

  task automatic cyc(input bit rstn, input bit clr, input bit pl, input int pp,
                     input bit c, input int cp);
    @(negedge clock);
    apply(rstn, clr, pl, pp, c, cp);
  endtask

  task automatic pmove(input int p);
    cyc(1, 0, 1, p, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic cmove(input int p);
    cyc(1, 0, 0, 0, 1, p);
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m0 = '0;
    m1 = '0;
    apply(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // Opening moves, occupied-cell and out-of-range rejects, off-turn strobes.
    cyc(1, 0, 0, 0, 1, 3);
    cyc(1, 0, 0, 0, 0, 0);
    pmove(5);
    cmove(5);
    cmove(1);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 10, 0, 0);
    cyc(1, 0, 1, 15, 0, 0);
    pmove(9);
    // Reset mid-game, then clear mid-game.
    cyc(0, 0, 1, 2, 1, 2);
    pmove(1);
    cyc(1, 1, 1, 4, 1, 4);
    cyc(1, 0, 1, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0);
    // Player win 1,2,3 against computer 4,5; strobes afterwards must be ignored.
    cyc(0, 0, 0, 0, 0, 0);
    pmove(1); cmove(4); pmove(2); cmove(5); pmove(3);
    cyc(1, 0, 1, 6, 1, 7);
    cyc(1, 0, 1, 7, 1, 8);
    // Draw: player 1,3,4,8,9 / computer 2,5,6,7.
    cyc(1, 1, 0, 0, 0, 0);
    pmove(1); cmove(2); pmove(3); cmove(5); pmove(4); cmove(6); pmove(8); cmove(7); pmove(9);
    cyc(1, 0, 1, 2, 1, 2);
    // Random games with occasional reset/clear.
    for (int n = 0; n < 4000; n++) begin
      int r, pp, cp;
      bit pl, c;
      r  = $urandom_range(0, 149);
      pl = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      pp = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 9);
      cp = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 9);
      cyc(r != 0, r == 1, pl, pp, c, cp);
    end
    @(negedge clock);
    @(negedge clock);
    if (q0.size() != 0 || q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d pending expectations, required 0/0",
               q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
